butterfly_pipe: RTL and testbench
=================================

// Module: butterfly_pipe
// PURPOSE
//   Pipelined, parametrised radix-2 DIT butterfly: a' = a + b*W, b' = a - b*W.
//   Successor to the combinational butterfly for the streaming FFT datapath:
//   - valid/ready handshake with backpressure;
//   - round-half-up product scaling and output saturation;
//   - per-transaction divide-by-2 stage scaling;
//   - a sideband tag carried alongside the data.
//   One instance sits between the twiddle ROM/stage controller and each stage's reorder buffer.
// PARAMETERS
//   DATA_WIDTH  21  signed width of all data and twiddle ports
//   FRAC_BITS   15  twiddle fractional bits; W = 1.0 is encoded as 1<<FRAC_BITS
//   TAG_WIDTH    8  width of the sideband tag (sample index / frame marker)
// PORTS
//   clk_i        in   1           clock, rising edge
//   rst_i        in   1           synchronous reset, active-high
//   in_valid_i   in   1           input beat valid
//   in_ready_o   out  1           input beat accepted when in_valid_i & in_ready_o
//   scale_i      in   1           1: halve both outputs (stage scaling)
//   tag_i        in   TAG_WIDTH   sideband, returned unchanged with its result
//   twid_re_i / twid_im_i  in  DATA_WIDTH  twiddle W, signed Q(FRAC_BITS)
//   a_re_i / a_im_i        in  DATA_WIDTH  operand a, signed
//   b_re_i / b_im_i        in  DATA_WIDTH  operand b, signed
//   out_valid_o  out  1           result valid
//   out_ready_i  in   1           downstream accepts result
//   tag_o        out  TAG_WIDTH   tag of the current result
//   a_re_o / a_im_o        out DATA_WIDTH  a' (saturated)
//   b_re_o / b_im_o        out DATA_WIDTH  b' (saturated)
//   ovf_o        out  1           sticky overflow flag (see CONFIGURATION)
//   ovf_clr_i    in   1           clears ovf_o
// BEHAVIOUR
//   Pipeline: 3 register stages, with all registers on clk_i.
//   - S1: registers the four 2*DATA_WIDTH products rr, ii, ri, ir, plus a, scale and tag.
//   - S2: computes re = rr-ii and im = ri+ir at 2*DATA_WIDTH+1 bits.
//     Adds 1<<(FRAC_BITS-1), then shifts right arithmetically by FRAC_BITS.
//     Saturates the result to DATA_WIDTH to form b*W.
//   - S3: computes a +/- bW at DATA_WIDTH+1 bits.
//     If scale is set, applies (x+1)>>>1.
//     Saturates to DATA_WIDTH and registers the result onto the outputs.
//   Latency: exactly 3 cycles from acceptance to out_valid_o when there is no backpressure.
//   Handshake:
//   - Global advance en = ~out_valid_o | out_ready_i, and in_ready_o = en (combinational).
//   - When en=1, every stage shifts one step; each stage has its own valid bit, so bubbles propagate.
//   - When en=0, all stages hold and the outputs stay stable until accepted.
//   - Throughput is 1 beat per cycle while out_ready_i=1.
//   - out_valid_o must not depend combinationally on out_ready_i.
//   Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; there is no wrap-around.
//   Reset (rst_i=1 at a clock edge):
//   - All stage valid bits, out_valid_o and ovf_o go to 0.
//   - Data and tag outputs go to 0.
//   - In-flight beats are discarded, including during a mid-stream reset.
//   - in_ready_o=1 in the cycle after reset.
//   Simultaneous events: when ovf_clr_i and a new overflow occur in the same cycle, the set wins.
//   W = -1.0 (-(1<<FRAC_BITS)) is legal; -max * -1.0 saturates in S2.
// CONFIGURATION
//   Macro BUTTERFLY_PIPE_OVF_FLAG_EN:
//   - Defined: ovf_o is set in the cycle a beat leaves S3 if any saturation (S2 or S3) hit that beat.
//     It holds until ovf_clr_i or rst_i.
//   - Undefined: no detection logic; ovf_o is tied to 0 and ovf_clr_i is ignored.
//   - Saturation itself is always present in both cases.
// TESTING (DATA_WIDTH=21, FRAC_BITS=15; 1.0 = 32768)
//   1. a=(1000,0), b=(500,0), W=(32768,0), scale=0
//      -> a'=(1500,0), b'=(500,0), out_valid_o exactly 3 cycles after acceptance.
//   2. a=(1000,0), b=(100,200), W=(0,-32768)
//      -> a'=(1200,-100), b'=(800,100); same beat with scale=1 -> a'=(600,-50), b'=(400,50).
//   3. a=(1048575,0), b=(1,0), W=(32768,0)
//      -> a'=(1048575,0) saturated, b'=(1048574,0).
//      ovf_o=1 with the macro defined (0 without); ovf_clr_i pulse -> ovf_o=0.
//   4. Stream 8 beats with tags 0..7 while out_ready_i=0 on cycles 4-8
//      -> outputs held stable, in_ready_o=0 while stalled.
//      -> all 8 results delivered in tag order with none lost or duplicated.
//   5. b=(3,0), W=(16384,0) (0.5)
//      -> bW=2 (1.5 rounds half-up); a=(0,0) gives a'=(2,0), b'=(-2,0).
//   6. Assert rst_i for 1 cycle while 3 beats are in flight
//      -> out_valid_o=0 next cycle, the flushed beats never appear, and a new beat emerges 3 cycles later.

Source files
------------

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT butterfly with rounding, saturation and valid/ready flow control.
// Optional sticky overflow flag enabled by defining BUTTERFLY_PIPE_OVF_FLAG_EN.
module butterfly_pipe #(
    parameter int DATA_WIDTH = 21,
    parameter int FRAC_BITS  = 15,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic                         scale_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    input  logic signed [DATA_WIDTH-1:0] twid_re_i,
    input  logic signed [DATA_WIDTH-1:0] twid_im_i,
    input  logic signed [DATA_WIDTH-1:0] a_re_i,
    input  logic signed [DATA_WIDTH-1:0] a_im_i,
    input  logic signed [DATA_WIDTH-1:0] b_re_i,
    input  logic signed [DATA_WIDTH-1:0] b_im_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [TAG_WIDTH-1:0]         tag_o,
    output logic signed [DATA_WIDTH-1:0] a_re_o,
    output logic signed [DATA_WIDTH-1:0] a_im_o,
    output logic signed [DATA_WIDTH-1:0] b_re_o,
    output logic signed [DATA_WIDTH-1:0] b_im_o,
    output logic                         ovf_o,
    input  logic                         ovf_clr_i
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH + 1;
    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [PW-1:0] PMAX = PW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [PW-1:0] PMIN = ~PMAX;
    localparam logic signed [DW:0]   ONE  = (DW + 1)'(1);

    // Both helpers return {saturated, value}.
    function automatic logic [DW:0] sat2(input logic signed [PW-1:0] x);
        logic signed [PW-1:0] r;
        r = (x + RND) >>> FRAC_BITS;
        return (r > PMAX) ? {1'b1, PMAX[DW-1:0]} :
               (r < PMIN) ? {1'b1, PMIN[DW-1:0]} : {1'b0, r[DW-1:0]};
    endfunction

    function automatic logic [DW:0] sat3(input logic signed [DW:0] x, input logic sc);
        logic signed [DW:0] t;
        t = sc ? (x + ONE) >>> 1 : x;
        return (t[DW] != t[DW-1]) ? {1'b1, t[DW], {(DW - 1){~t[DW]}}} : {1'b0, t[DW-1:0]};
    endfunction

    logic en;
    assign en = ~out_valid_o | out_ready_i;
    assign in_ready_o = en;

    logic v1, sc1;
    logic [TAG_WIDTH-1:0] tg1;
    logic signed [2*DW-1:0] rr, ii, ri, ir;
    logic signed [DW-1:0] ar1, ai1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1 <= 1'b0;
        end else if (en) begin
            v1  <= in_valid_i;
            sc1 <= scale_i;
            tg1 <= tag_i;
            ar1 <= a_re_i;
            ai1 <= a_im_i;
            rr  <= (2*DW)'(b_re_i) * (2*DW)'(twid_re_i);
            ii  <= (2*DW)'(b_im_i) * (2*DW)'(twid_im_i);
            ri  <= (2*DW)'(b_re_i) * (2*DW)'(twid_im_i);
            ir  <= (2*DW)'(b_im_i) * (2*DW)'(twid_re_i);
        end
    end

    logic signed [PW-1:0] re_w, im_w;
    logic [DW:0] p_re, p_im;
    assign re_w = PW'(rr) - PW'(ii);
    assign im_w = PW'(ri) + PW'(ir);
    assign p_re = sat2(re_w);
    assign p_im = sat2(im_w);

    logic v2, sc2, o2;
    logic [TAG_WIDTH-1:0] tg2;
    logic signed [DW-1:0] ar2, ai2, bwr, bwi;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v2 <= 1'b0;
        end else if (en) begin
            v2  <= v1;
            sc2 <= sc1;
            tg2 <= tg1;
            ar2 <= ar1;
            ai2 <= ai1;
            bwr <= p_re[DW-1:0];
            bwi <= p_im[DW-1:0];
            o2  <= p_re[DW] | p_im[DW];
        end
    end

    logic signed [DW:0] x0, x1, x2, x3;
    logic [DW:0] q0, q1, q2, q3;
    logic hit;
    assign x0 = (DW+1)'(ar2) + (DW+1)'(bwr);
    assign x1 = (DW+1)'(ai2) + (DW+1)'(bwi);
    assign x2 = (DW+1)'(ar2) - (DW+1)'(bwr);
    assign x3 = (DW+1)'(ai2) - (DW+1)'(bwi);
    assign q0 = sat3(x0, sc2);
    assign q1 = sat3(x1, sc2);
    assign q2 = sat3(x2, sc2);
    assign q3 = sat3(x3, sc2);
    assign hit = o2 | q0[DW] | q1[DW] | q2[DW] | q3[DW];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            tag_o       <= '0;
            a_re_o      <= '0;
            a_im_o      <= '0;
            b_re_o      <= '0;
            b_im_o      <= '0;
        end else if (en) begin
            out_valid_o <= v2;
            tag_o       <= tg2;
            a_re_o      <= q0[DW-1:0];
            a_im_o      <= q1[DW-1:0];
            b_re_o      <= q2[DW-1:0];
            b_im_o      <= q3[DW-1:0];
        end
    end

`ifdef BUTTERFLY_PIPE_OVF_FLAG_EN
    // A new overflow takes priority over a clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_o <= 1'b0;
        end else if (en && v2 && hit) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{ovf_clr_i, hit};
    assign ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed vector table plus stall, overflow and mid-stream reset sequences.
module tb_butterfly_pipe;
    localparam int DW = 21;
    localparam int TW = 8;
`ifdef BUTTERFLY_PIPE_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, scale, out_valid, out_ready, ovf, ovf_clr;
    logic [TW-1:0] tag_in, tag_out;
    logic signed [DW-1:0] wr, wi, ar, ai, br, bi, oar, oai, obr, obi;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    butterfly_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(15), .TAG_WIDTH(TW)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .scale_i(scale), .tag_i(tag_in),
        .twid_re_i(wr), .twid_im_i(wi),
        .a_re_i(ar), .a_im_i(ai), .b_re_i(br), .b_im_i(bi),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .tag_o(tag_out),
        .a_re_o(oar), .a_im_o(oai), .b_re_o(obr), .b_im_o(obi),
        .ovf_o(ovf), .ovf_clr_i(ovf_clr)
    );

    typedef struct {
        int ar, ai, br, bi, wr, wi;
        bit sc;
        int ear, eai, ebr, ebi;
        bit eovf;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input vec_t v, input logic [TW-1:0] t, input string nm);
        int lat;
        @(negedge clk);
        ar = DW'(v.ar); ai = DW'(v.ai); br = DW'(v.br); bi = DW'(v.bi);
        wr = DW'(v.wr); wi = DW'(v.wi); scale = v.sc; tag_in = t; in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
        chk({nm, " latency"}, lat, 3);
        chk({nm, " a_re"}, oar, v.ear);
        chk({nm, " a_im"}, oai, v.eai);
        chk({nm, " b_re"}, obr, v.ebr);
        chk({nm, " b_im"}, obi, v.ebi);
        chk({nm, " tag"}, tag_out, t);
        chk({nm, " ovf"}, ovf, v.eovf & OVF_EN);
    endtask

    initial begin
        int k, got, seen;
        logic signed [DW-1:0] hold_a;
        logic [TW-1:0] hold_t;
        tbl[0] = '{1000, 0, 500, 0, 32768, 0, 1'b0, 1500, 0, 500, 0, 1'b0};
        tbl[1] = '{1000, 0, 100, 200, 0, -32768, 1'b0, 1200, -100, 800, 100, 1'b0};
        tbl[2] = '{1000, 0, 100, 200, 0, -32768, 1'b1, 600, -50, 400, 50, 1'b0};
        tbl[3] = '{1048575, 0, 1, 0, 32768, 0, 1'b0, 1048575, 0, 1048574, 0, 1'b1};
        tbl[4] = '{0, 0, 3, 0, 16384, 0, 1'b0, 2, 0, -2, 0, 1'b0};
        tbl[5] = '{0, 0, -1048576, 0, -32768, 0, 1'b0, 1048575, 0, -1048575, 0, 1'b1};
        tbl[6] = '{-1048576, 0, -1, 0, 32768, 0, 1'b0, -1048576, 0, -1048575, 0, 1'b1};
        tbl[7] = '{-3, 0, 0, 0, 0, 0, 1'b1, -1, 0, -1, 0, 1'b0};
        tbl[8] = '{0, 0, -3, 0, 16384, 0, 1'b0, -1, 0, 1, 0, 1'b0};
        tbl[9] = '{1048575, 0, 1048575, 0, 32768, 0, 1'b1, 1048575, 0, 0, 0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0; scale = 1'b0;
        tag_in = '0; ar = '0; ai = '0; br = '0; bi = '0; wr = '0; wi = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset a_re", oar, 0);
        chk("reset b_im", obi, 0);
        chk("reset tag", tag_out, 0);
        chk("reset ovf", ovf, 0);

        // Clear held high: a saturating beat must still raise the flag.
        ovf_clr = 1'b1;
        for (int i = 0; i < 10; i++) send(tbl[i], TW'(i + 1), $sformatf("vec%0d", i));
        ovf_clr = 1'b0;

        send(tbl[3], 8'h33, "sticky");
        repeat (3) @(negedge clk);
        chk("ovf sticky", ovf, OVF_EN);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf cleared", ovf, 0);

        k = 0; got = 0; hold_a = '0; hold_t = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 8);
            if (k < 8) begin
                in_valid = 1'b1; tag_in = TW'(k); scale = 1'b0;
                ar = DW'(k * 100); ai = DW'(-k); br = DW'(k); bi = '0; wr = DW'(32768); wi = '0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 4 && c <= 8) chk($sformatf("stall in_ready c%0d", c), in_ready, 0);
            if (c == 4) begin
                hold_a = oar; hold_t = tag_out;
            end
            if (c > 4 && c <= 8) begin
                chk($sformatf("stall hold a_re c%0d", c), oar, hold_a);
                chk($sformatf("stall hold tag c%0d", c), tag_out, hold_t);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("stream tag #%0d", got), tag_out, got);
                chk($sformatf("stream a_re #%0d", got), oar, got * 101);
                chk($sformatf("stream b_re #%0d", got), obr, got * 99);
                got++;
            end
            if (in_valid && in_ready) k++;
        end
        in_valid = 1'b0;
        chk("stream delivered", got, 8);
        @(negedge clk);
        chk("stream no extra", out_valid, 0);

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; tag_in = TW'(16 + i);
            ar = DW'(5); ai = '0; br = DW'(1); bi = '0; wr = DW'(32768); wi = '0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset in_ready", in_ready, 1);
        chk("midreset a_re", oar, 0);
        chk("midreset tag", tag_out, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flushed beats", seen, 0);
        send(tbl[0], 8'h20, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
